// File: rtl/dsc_mul_sched.sv
// dsc_mul_sched: round-robin scheduler that shares one serial dsc_mul among
// NUM_REQ requesters. It accepts one operand triple, runs the multiplier
// (reset, enable, wait for ov, settle, capture) and returns the product and
// the run length to the requester that owns the operation.
//
// Optional feature: define DSC_SCHED_WATCHDOG_EN to abort a run that reaches
// MAX_CYC cycles without mul_ov. The abort reports err=1, z_out=0 and
// cyc_out=MAX_CYC. Without the macro, RUN waits for mul_ov indefinitely and
// err is tied low.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | multiplier held in reset, grant the next requester
// LOAD  | operands latched, multiplier still in reset, counter cleared
// RUN   | multiplier enabled, counting cycles until mul_ov
// DRAIN | enable dropped, mul_z settles
// DONE  | result registered, done pulse to owner
module dsc_mul_sched #(
    parameter int              NUM_REQ = 4,
    parameter int              WIDTH   = 10,
    parameter int              CYC_W   = 24,
    parameter longint unsigned MAX_CYC = 64'd1 << (3 * WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    input  logic [NUM_REQ*WIDTH-1:0] c_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [3*WIDTH-1:0]       z_out,
    output logic [CYC_W-1:0]         cyc_out,
    output logic                     err,
    output logic                     busy,
    output logic                     mul_rst,
    output logic                     mul_en,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic [WIDTH-1:0]         mul_c,
    input  logic [3*WIDTH-1:0]       mul_z,
    input  logic                     mul_ov
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] cand;
    logic             found;
    int               cand_i;
    logic [CYC_W-1:0] cnt;
    logic [CYC_W-1:0] cnt_nxt;

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];
    logic [WIDTH-1:0] c_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign a_arr[g] = a_in[g*WIDTH +: WIDTH];
        assign b_arr[g] = b_in[g*WIDTH +: WIDTH];
        assign c_arr[g] = c_in[g*WIDTH +: WIDTH];
    end

    // Round-robin pick: scan downward from the farthest slot so the slot
    // nearest the pointer is written last and wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        cand_i  = 0;
        if (state == S_IDLE) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand_i = int'(ptr) + k;
                if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
                cand = IDX_W'(cand_i);
                if (req[cand]) begin
                    gnt_idx = cand;
                    found   = 1'b1;
                end
            end
            if (found) gnt[gnt_idx] = 1'b1;
        end
    end

    // Done pulse routed to the owner for the single DONE cycle.
    always_comb begin
        done = '0;
        if (state == S_DONE) done[owner] = 1'b1;
    end

    assign busy    = (state != S_IDLE);
    assign mul_en  = (state == S_RUN);
    assign mul_rst = !((state == S_RUN) || (state == S_DRAIN));
    assign cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;

`ifdef DSC_SCHED_WATCHDOG_EN
    logic wd_hit;

    // Sequencer with watchdog abort out of RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            owner   <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_c   <= '0;
            cnt     <= '0;
            z_out   <= '0;
            cyc_out <= '0;
            err     <= 1'b0;
            wd_hit  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner <= gnt_idx;
                        mul_a <= a_arr[gnt_idx];
                        mul_b <= b_arr[gnt_idx];
                        mul_c <= c_arr[gnt_idx];
                        ptr   <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt    <= '0;
                    wd_hit <= 1'b0;
                    state  <= S_RUN;
                end
                S_RUN: begin
                    cnt <= cnt_nxt;
                    if (mul_ov) begin
                        state <= S_DRAIN;
                    end else if (64'(cnt_nxt) >= MAX_CYC) begin
                        wd_hit <= 1'b1;
                        state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    z_out   <= wd_hit ? '0 : mul_z;
                    cyc_out <= cnt;
                    err     <= wd_hit;
                    state   <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    logic unused_max_cyc;
    assign unused_max_cyc = ^MAX_CYC;
    assign err            = 1'b0;

    // Sequencer: RUN waits for mul_ov with no abort path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            owner   <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_c   <= '0;
            cnt     <= '0;
            z_out   <= '0;
            cyc_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner <= gnt_idx;
                        mul_a <= a_arr[gnt_idx];
                        mul_b <= b_arr[gnt_idx];
                        mul_c <= c_arr[gnt_idx];
                        ptr   <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt   <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    cnt <= cnt_nxt;
                    if (mul_ov) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    z_out   <= mul_z;
                    cyc_out <= cnt;
                    state   <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_dsc_mul_sched.sv
// Bench for dsc_mul_sched: a stub multiplier, a cycle-level expectation
// model built from the scheduling rules, a vector table, directed sequences
// and a randomized phase.
module tb_dsc_mul_sched;
    localparam int NR = 4;
    localparam int W  = 10;
    localparam int ZW = 30;
    localparam int CW = 24;
`ifdef DSC_SCHED_WATCHDOG_EN
    localparam longint unsigned TB_MAXC = 100;
`else
    localparam longint unsigned TB_MAXC = 64'd1 << 30;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR*W-1:0] a_in, b_in, c_in;
    logic [NR-1:0] gnt, done;
    logic [ZW-1:0] z_out, mul_z;
    logic [CW-1:0] cyc_out;
    logic          err, busy, mul_rst, mul_en, mul_ov;
    logic [W-1:0]  mul_a, mul_b, mul_c;

    always #5 clk = ~clk;

    dsc_mul_sched #(.NUM_REQ(NR), .WIDTH(W), .CYC_W(CW), .MAX_CYC(TB_MAXC)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .gnt(gnt), .done(done), .z_out(z_out), .cyc_out(cyc_out), .err(err),
        .busy(busy), .mul_rst(mul_rst), .mul_en(mul_en), .mul_a(mul_a),
        .mul_b(mul_b), .mul_c(mul_c), .mul_z(mul_z), .mul_ov(mul_ov)
    );

    // requester operand storage
    logic [W-1:0] a_v [NR];
    logic [W-1:0] b_v [NR];
    logic [W-1:0] c_v [NR];
    always_comb begin
        a_in = '0; b_in = '0; c_in = '0;
        for (int i = 0; i < NR; i++) begin
            a_in[i*W +: W] = a_v[i];
            b_in[i*W +: W] = b_v[i];
            c_in[i*W +: W] = c_v[i];
        end
    end

    // stub multiplier: ov in the stub_len-th enabled cycle, z valid afterwards
    int          en_cnt = 0;
    int          stub_len = 5;
    bit          stub_stuck = 1'b0;
    logic [ZW-1:0] prod;
    assign prod = ZW'(mul_a) * ZW'(mul_b) * ZW'(mul_c);
    always_ff @(posedge clk) begin
        if (mul_rst) en_cnt <= 0;
        else if (mul_en) en_cnt <= en_cnt + 1;
    end
    assign mul_ov = !stub_stuck && mul_en && (en_cnt == stub_len - 1);
    assign mul_z  = stub_stuck ? '1 : ((en_cnt >= stub_len) ? prod : '0);

    // model state
    int total = 0, bad = 0, cyc = 0;
    int want [NR];
    bit gprev [NR];
    bit pending = 0;
    int p_owner, p_g, p_len, p_done;
    logic [ZW-1:0] p_z;
    bit p_err;
    int ptr_m = 0;
    logic [ZW-1:0] held_z = '0;
    int held_cyc = 0;
    bit held_err = 0;
    bit rand_mode = 0;
    int fixed_len = 0;
    int en_seen = 0;
    int glog[$], gcyc[$], dcyc[$];

    typedef struct { int idx; int a; int b; int c; longint z; } vec_t;
    vec_t tbl [6];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int arb(logic [NR-1:0] r, int p);
        for (int k = 0; k < NR; k++) begin
            int j = (p + k) % NR;
            if (((r >> j) & NR'(1)) != '0) return j;
        end
        return -1;
    endfunction

    task automatic rand_ops(int i);
        a_v[i] = W'($urandom_range(0, 1023));
        b_v[i] = W'($urandom_range(0, 1023));
        c_v[i] = W'($urandom_range(0, 1023));
    endtask

    function automatic bit any_want();
        for (int i = 0; i < NR; i++) if (want[i] > 0 || gprev[i]) return 1;
        return 0;
    endfunction

    // one cycle: update requesters, then check every output against the model
    task automatic step();
        int eg;
        logic [NR-1:0] ed;
        bit run_c, rst_c;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (gprev[i]) begin
                gprev[i] = 0;
                if (want[i] > 0) want[i]--;
                if (want[i] > 0) rand_ops(i);
            end
            if (rand_mode) begin
                if (want[i] == 0) begin
                    if ($urandom_range(0, 5) == 0) begin rand_ops(i); want[i] = 1; end
                end else if ($urandom_range(0, 39) == 0) begin
                    want[i] = 0;
                end
            end
            req[i] = (want[i] > 0);
        end
        #1;
        if (mul_en) en_seen++;
        eg = pending ? -1 : arb(req, ptr_m);
        chk("gnt", gnt, (eg < 0) ? '0 : (NR'(1) << eg));
        ed = '0;
        if (pending && cyc == p_done) ed = NR'(1) << p_owner;
        chk("done", done, ed);
        chk("busy", busy, pending);
        run_c = pending && cyc >= p_g + 2 && cyc <= p_g + 1 + p_len;
        chk("mul_en", mul_en, run_c);
        if (!(pending && cyc == p_done)) begin
            rst_c = !(pending && cyc >= p_g + 2 && cyc <= p_g + 2 + p_len);
            chk("mul_rst", mul_rst, rst_c);
        end
        if (pending && cyc == p_done) begin
            held_z = p_z; held_cyc = p_len; held_err = p_err;
            dcyc.push_back(cyc);
            pending = 0;
        end
        chk("z_out", z_out, held_z);
        chk("cyc_out", cyc_out, held_cyc);
        chk("err", err, held_err);
        if (eg >= 0 && gnt == (NR'(1) << eg)) begin
            gprev[eg] = 1;
            pending = 1;
            p_owner = eg;
            p_g = cyc;
            if (stub_stuck) begin
                p_len = int'(TB_MAXC); p_z = '0; p_err = 1;
            end else begin
                p_len = (fixed_len > 0) ? fixed_len : $urandom_range(1, 12);
                p_z = ZW'(longint'(a_v[eg]) * longint'(b_v[eg]) * longint'(c_v[eg]));
                p_err = 0;
            end
            stub_len = p_len;
            p_done = cyc + p_len + 3;
            ptr_m = (eg + 1) % NR;
            glog.push_back(eg);
            gcyc.push_back(cyc);
        end
    endtask

    task automatic run_idle(int maxc);
        int n = 0;
        do begin step(); n++; end while ((pending || any_want()) && n < maxc);
        if (pending || any_want()) begin
            total++; bad++;
            $display("FAIL run_timeout cyc=%0d got=busy want=idle within %0d", cyc, maxc);
            pending = 0;
            for (int i = 0; i < NR; i++) begin want[i] = 0; gprev[i] = 0; end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin want[i] = 0; gprev[i] = 0; end
        pending = 0; ptr_m = 0; held_z = '0; held_cyc = 0; held_err = 0;
        step(); step();
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        int exp5 [5];
        int exp4 [4];
        int n;
        for (int i = 0; i < NR; i++) begin
            a_v[i] = '0; b_v[i] = '0; c_v[i] = '0; want[i] = 0; gprev[i] = 0;
        end
        tbl[0] = '{0, 15, 15, 15, 3375};
        tbl[1] = '{1, 1023, 1023, 1023, 1070599167};
        tbl[2] = '{2, 0, 500, 77, 0};
        tbl[3] = '{3, 1, 1, 1, 1};
        tbl[4] = '{0, 2, 3, 4, 24};
        tbl[5] = '{2, 100, 200, 3, 60000};

        // reset state
        @(negedge clk); #1;
        chk("rst_gnt", gnt, 0);      chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);    chk("rst_mul_en", mul_en, 0);
        chk("rst_mul_rst", mul_rst, 1); chk("rst_z", z_out, 0);
        chk("rst_cyc", cyc_out, 0);  chk("rst_err", err, 0);
        chk("rst_mul_a", mul_a, 0);  chk("rst_mul_b", mul_b, 0);
        chk("rst_mul_c", mul_c, 0);
        rst = 1'b1;

        // vector table, one request at a time
        fixed_len = 7;
        for (int t = 0; t < 6; t++) begin
            a_v[tbl[t].idx] = W'(tbl[t].a);
            b_v[tbl[t].idx] = W'(tbl[t].b);
            c_v[tbl[t].idx] = W'(tbl[t].c);
            want[tbl[t].idx] = 1;
            glog.delete();
            en_seen = 0;
            run_idle(60);
            chk("tbl_z", z_out, tbl[t].z);
            chk("tbl_cyc", cyc_out, en_seen);
            chk("tbl_owner", (glog.size() > 0) ? glog[glog.size()-1] : -1, tbl[t].idx);
        end
        fixed_len = 0;

        // all four together, requester 0 re-requests after its grant
        do_reset();
        glog.delete();
        for (int i = 0; i < NR; i++) begin
            a_v[i] = W'(i + 3); b_v[i] = W'(2 * i + 5); c_v[i] = W'(100 + i); want[i] = 1;
        end
        want[0] = 2;
        run_idle(200);
        exp5 = '{0, 1, 2, 3, 0};
        chk("rr_count", glog.size(), 5);
        for (int k = 0; k < 5; k++) if (k < glog.size()) chk("rr_order", glog[k], exp5[k]);

        // 0 and 2 held continuously: alternate with one idle cycle between
        do_reset();
        glog.delete(); gcyc.delete(); dcyc.delete();
        rand_ops(0); rand_ops(2);
        want[0] = 2; want[2] = 2;
        run_idle(200);
        exp4 = '{0, 2, 0, 2};
        chk("alt_count", glog.size(), 4);
        for (int k = 0; k < 4; k++) if (k < glog.size()) chk("alt_order", glog[k], exp4[k]);
        for (int k = 0; k < 3; k++)
            if (k + 1 < gcyc.size() && k < dcyc.size()) chk("alt_gap", gcyc[k+1] - dcyc[k], 1);

        // asynchronous reset in the middle of RUN
        fixed_len = 10;
        rand_ops(1); want[1] = 1;
        n = 0;
        do begin step(); n++; end while (!(pending && cyc >= p_g + 4) && n < 30);
        chk("mid_reached_run", pending && cyc >= p_g + 4, 1);
        #2; rst = 1'b0; #1;
        chk("mid_mul_rst", mul_rst, 1);
        chk("mid_mul_en", mul_en, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        do_reset();
        fixed_len = 0;
        glog.delete();
        rand_ops(0); rand_ops(3);
        want[3] = 1; want[0] = 1;
        run_idle(100);
        chk("post_rst_count", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("post_rst_first", glog[0], 0);
            chk("post_rst_second", glog[1], 3);
        end

`ifdef DSC_SCHED_WATCHDOG_EN
        // watchdog: multiplier never raises ov
        stub_stuck = 1'b1;
        rand_ops(2); want[2] = 1;
        run_idle(150);
        chk("wd_err", err, 1);
        chk("wd_cyc", cyc_out, 100);
        chk("wd_z", z_out, 0);
        stub_stuck = 1'b0;
        rand_ops(1); want[1] = 1;
        run_idle(60);
        chk("wd_err_clear", err, 0);
`endif

        // randomized traffic including requesters that give up before grant
        rand_mode = 1;
        repeat (2000) step();
        rand_mode = 0;
        for (int i = 0; i < NR; i++) if (!gprev[i]) want[i] = 0;
        run_idle(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
